// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF input synchroniser, false-start rejection, parity and
// framing checks, and a valid/ready holding register that flags overruns.
module uart_rx_param #(
   parameter int p_CLKs_PB   = 217,
   parameter int p_DATA_BITS = 8,
   parameter int p_PARITY    = 0,
   parameter int p_STOP_BITS = 1
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_n,
   input  logic                   i_Rx_UART,
   output logic [p_DATA_BITS-1:0] o_Rx_Byte,
   output logic                   o_Rx_Valid,
   input  logic                   i_Rx_Ready,
   output logic                   o_Parity_Err,
   output logic                   o_Frame_Err,
   output logic                   o_Overrun,
   output logic                   o_Busy
);

   localparam int c_CNT_W = $clog2(p_CLKs_PB);
   localparam int c_IDX_W = $clog2(p_DATA_BITS);
   localparam logic [c_CNT_W-1:0] c_CNT_ZERO = {c_CNT_W{1'b0}};
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_MID      = c_CNT_W'((p_CLKs_PB - 1) / 2);
   localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(p_CLKs_PB - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_ZERO = {c_IDX_W{1'b0}};
   localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(p_DATA_BITS - 1);
   localparam logic               c_STOP_LAST = 1'(p_STOP_BITS - 1);
   localparam logic               c_HAS_PAR   = (p_PARITY != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                   state_r;
   logic                     rx_meta_r;
   logic                     rx_s_r;
   logic [c_CNT_W-1:0]       clk_cnt_r;
   logic [c_IDX_W-1:0]       bit_idx_r;
   logic                     stop_cnt_r;
   logic [p_DATA_BITS-1:0]   shift_r;
   logic                     par_err_r;
   logic                     frm_err_r;
   logic                     armed_r;
   logic [p_DATA_BITS-1:0]   byte_r;
   logic                     valid_r;
   logic                     perr_r;
   logic                     ferr_r;
   logic                     ovr_r;
   logic                     busy_r;

   logic                     bit_tick_s;
   logic                     stop_done_s;
   logic                     take_s;

   function automatic logic parity_exp_f(input logic [p_DATA_BITS-1:0] data);
      if (p_PARITY == 1) begin
         return ~^data;
      end else begin
         return ^data;
      end
   endfunction

   assign bit_tick_s  = (clk_cnt_r == c_LAST);
   assign stop_done_s = (state_r == S_STOP) && bit_tick_s && (stop_cnt_r == c_STOP_LAST);
   assign take_s      = valid_r && i_Rx_Ready;

   assign o_Rx_Byte    = byte_r;
   assign o_Rx_Valid   = valid_r;
   assign o_Parity_Err = perr_r;
   assign o_Frame_Err  = ferr_r;
   assign o_Overrun    = ovr_r;
   assign o_Busy       = busy_r;

   // Two-flop synchroniser for the asynchronous RX line (idles high).
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         rx_meta_r <= 1'b1;
         rx_s_r    <= 1'b1;
      end else begin
         rx_meta_r <= i_Rx_UART;
         rx_s_r    <= rx_meta_r;
      end
   end

   // Frame receive FSM together with the output holding register.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_r    <= S_IDLE;
         clk_cnt_r  <= c_CNT_ZERO;
         bit_idx_r  <= c_IDX_ZERO;
         stop_cnt_r <= 1'b0;
         shift_r    <= {p_DATA_BITS{1'b0}};
         par_err_r  <= 1'b0;
         frm_err_r  <= 1'b0;
         armed_r    <= 1'b1;
         byte_r     <= {p_DATA_BITS{1'b0}};
         valid_r    <= 1'b0;
         perr_r     <= 1'b0;
         ferr_r     <= 1'b0;
         ovr_r      <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         ovr_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               clk_cnt_r <= c_CNT_ZERO;
               // A break leaves armed_r clear until the line has been seen high again.
               if (rx_s_r) begin
                  armed_r <= 1'b1;
               end else if (armed_r) begin
                  state_r <= S_START;
                  busy_r  <= 1'b1;
               end
            end
            S_START: begin
               if (clk_cnt_r == c_MID) begin
                  clk_cnt_r <= c_CNT_ZERO;
                  if (rx_s_r) begin
                     state_r <= S_IDLE;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r   <= S_DATA;
                     bit_idx_r <= c_IDX_ZERO;
                     par_err_r <= 1'b0;
                     frm_err_r <= 1'b0;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + c_CNT_ONE;
               end
            end
            S_DATA: begin
               if (bit_tick_s) begin
                  clk_cnt_r <= c_CNT_ZERO;
                  shift_r   <= {rx_s_r, shift_r[p_DATA_BITS-1:1]};
                  if (bit_idx_r == c_IDX_LAST) begin
                     bit_idx_r  <= c_IDX_ZERO;
                     stop_cnt_r <= 1'b0;
                     state_r    <= c_HAS_PAR ? S_PARITY : S_STOP;
                  end else begin
                     bit_idx_r <= bit_idx_r + c_IDX_ONE;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + c_CNT_ONE;
               end
            end
            S_PARITY: begin
               if (bit_tick_s) begin
                  clk_cnt_r  <= c_CNT_ZERO;
                  par_err_r  <= (rx_s_r != parity_exp_f(shift_r));
                  stop_cnt_r <= 1'b0;
                  state_r    <= S_STOP;
               end else begin
                  clk_cnt_r <= clk_cnt_r + c_CNT_ONE;
               end
            end
            S_STOP: begin
               if (bit_tick_s) begin
                  clk_cnt_r <= c_CNT_ZERO;
                  if (!rx_s_r) begin
                     frm_err_r <= 1'b1;
                     armed_r   <= 1'b0;
                  end
                  if (stop_cnt_r == c_STOP_LAST) begin
                     state_r <= S_IDLE;
                     busy_r  <= 1'b0;
                  end else begin
                     stop_cnt_r <= stop_cnt_r + 1'b1;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + c_CNT_ONE;
               end
            end
            default: begin
               state_r   <= S_IDLE;
               clk_cnt_r <= c_CNT_ZERO;
               busy_r    <= 1'b0;
            end
         endcase

         // The final stop sample folds straight into the delivered framing flag.
         if (stop_done_s) begin
            if (!valid_r || take_s) begin
               byte_r  <= shift_r;
               perr_r  <= par_err_r;
               ferr_r  <= frm_err_r | ~rx_s_r;
               valid_r <= 1'b1;
            end else begin
               ovr_r <= 1'b1;
            end
         end else if (take_s) begin
            valid_r <= 1'b0;
         end
      end
   end

endmodule
